// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared opcode, state and ALU encodings for the micro sequencer
package micro_seq_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC1, EXEC2, HALT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_LDB, OP_MOVAB, OP_MOVBA, OP_ADD, OP_SUB, OP_AND,
    OP_OR, OP_OUT, OP_JMP, OP_JZ, OP_JC, OP_CLRA, OP_CLRB, OP_HLT
  } opcode_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
  typedef struct packed {
    logic a_ld_imm;
    logic a_ld_bus;
    logic a_drv;
    logic b_ld_imm;
    logic b_ld_bus;
    logic b_drv;
    logic a_lrst;
    logic b_lrst;
    logic alu_ld;
    logic alu_drv;
    logic out_ld;
  } strobe_t;
  function automatic logic is_alu(opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction
endpackage

// File: rtl/micro_seq_if.sv
// micro_seq_if: sequencer <-> datapath/program-memory signal bundle
interface micro_seq_if;
  logic       en;
  logic [7:0] instr;
  logic       z_in;
  logic       c_in;
  logic [3:0] pc;
  logic [3:0] imm;
  logic       a_ld_imm;
  logic       a_ld_bus;
  logic       a_drv;
  logic       b_ld_imm;
  logic       b_ld_bus;
  logic       b_drv;
  logic       a_lrst;
  logic       b_lrst;
  logic       alu_ld;
  logic       alu_drv;
  logic [1:0] alu_op;
  logic       out_ld;
  logic       halted;
  modport master (
    input  en, instr, z_in, c_in,
    output pc, imm, a_ld_imm, a_ld_bus, a_drv, b_ld_imm, b_ld_bus, b_drv,
           a_lrst, b_lrst, alu_ld, alu_drv, alu_op, out_ld, halted
  );
  modport slave (
    output en, instr, z_in, c_in,
    input  pc, imm, a_ld_imm, a_ld_bus, a_drv, b_ld_imm, b_ld_bus, b_drv,
           a_lrst, b_lrst, alu_ld, alu_drv, alu_op, out_ld, halted
  );
endinterface

// File: rtl/micro_dec.sv
// micro_dec: Moore strobe decode from registered state, opcode and flags
module micro_dec
  import micro_seq_pkg::*;
(
  input  state_t     state,
  input  logic [7:4] ir,
  input  logic       zf,
  input  logic       cf,
  output strobe_t    s,
  output alu_op_t    alu_op,
  output logic       pc_ld
);
  opcode_t op;
  logic    e1;
  logic    e2;
  assign op     = opcode_t'(ir);
  assign e1     = state == EXEC1;
  assign e2     = state == EXEC2;
  assign alu_op = is_alu(op) ? alu_op_t'(ir[5:4]) : ALU_ADD;
  assign pc_ld  = e1 && (op == OP_JMP || (op == OP_JZ && zf) || (op == OP_JC && cf));
  // EXEC2 is only ever entered for ALU ops, so it needs no opcode qualifier
  always_comb begin
    s          = '0;
    s.a_ld_imm = e1 && op == OP_LDA;
    s.b_ld_imm = e1 && op == OP_LDB;
    s.a_drv    = e1 && (op == OP_MOVAB || op == OP_OUT);
    s.b_ld_bus = e1 && op == OP_MOVAB;
    s.b_drv    = e1 && (op == OP_MOVBA || is_alu(op));
    s.a_ld_bus = (e1 && op == OP_MOVBA) || e2;
    s.alu_ld   = e1 && is_alu(op);
    s.out_ld   = e1 && op == OP_OUT;
    s.a_lrst   = e1 && op == OP_CLRA;
    s.b_lrst   = e1 && op == OP_CLRB;
    s.alu_drv  = e2;
  end
endmodule

// File: rtl/micro_seq.sv
// micro_seq: fetch/decode/execute FSM holding pc, ir and ALU flags
module micro_seq
  import micro_seq_pkg::*;
(
  input logic         clk,
  input logic         grst,
  micro_seq_if.master bus
);
  state_t     state;
  logic [7:0] ir;
  logic [3:0] pc;
  logic       zf;
  logic       cf;
  logic       pc_ld;
  strobe_t    s;
  strobe_t    g;
  alu_op_t    alu_op;
  micro_dec u_dec (
    .state  (state),
    .ir     (ir[7:4]),
    .zf     (zf),
    .cf     (cf),
    .s      (s),
    .alu_op (alu_op),
    .pc_ld  (pc_ld)
  );
  always_ff @(posedge clk or posedge grst)
    if (grst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
    end else if (bus.en)
      case (state)
        FETCH: begin
          ir    <= bus.instr;
          pc    <= pc + 4'd1;
          state <= DECODE;
        end
        DECODE: state <= opcode_t'(ir[7:4]) == OP_HLT ? HALT : EXEC1;
        EXEC1: begin
          if (pc_ld) pc <= ir[3:0];
          state <= is_alu(opcode_t'(ir[7:4])) ? EXEC2 : FETCH;
        end
        EXEC2: begin
          zf    <= bus.z_in;
          cf    <= bus.c_in;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
  // a stalled step must not let the datapath act on a stale strobe
  assign g            = bus.en ? s : '0;
  assign bus.a_ld_imm = g.a_ld_imm;
  assign bus.a_ld_bus = g.a_ld_bus;
  assign bus.a_drv    = g.a_drv;
  assign bus.b_ld_imm = g.b_ld_imm;
  assign bus.b_ld_bus = g.b_ld_bus;
  assign bus.b_drv    = g.b_drv;
  assign bus.a_lrst   = g.a_lrst;
  assign bus.b_lrst   = g.b_lrst;
  assign bus.alu_ld   = g.alu_ld;
  assign bus.alu_drv  = g.alu_drv;
  assign bus.out_ld   = g.out_ld;
  assign bus.alu_op   = alu_op;
  assign bus.pc       = pc;
  assign bus.imm      = ir[3:0];
  assign bus.halted   = state == HALT;
endmodule

// File: tb/tb_micro_seq.sv
// tb_micro_seq: instruction-level reference model feeding a per-cycle scoreboard
module tb_micro_seq;
  localparam logic [10:0] S_AI = 11'h400, S_AB = 11'h200, S_AD = 11'h100, S_BI = 11'h080;
  localparam logic [10:0] S_BB = 11'h040, S_BD = 11'h020, S_AR = 11'h010, S_BR = 11'h008;
  localparam logic [10:0] S_ALD = 11'h004, S_ADRV = 11'h002, S_OUT = 11'h001;
  typedef struct packed {
    logic [3:0]  pc;
    logic [3:0]  imm;
    logic [10:0] s;
    logic [1:0]  op;
    logic        h;
  } ev_t;
  logic        clk = 1'b0;
  logic        grst = 1'b0;
  logic [7:0]  mem [16];
  ev_t         exp_q [$];
  logic [1:0]  zc [$];
  logic        active = 1'b0;
  int          rd, zrd, halt_cmp, cyc, checks, errors;
  logic        abort;
  logic [10:0] act_s;
  micro_seq_if bus ();
  micro_seq dut (.clk(clk), .grst(grst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.instr = mem[bus.pc];
  assign act_s = {bus.a_ld_imm, bus.a_ld_bus, bus.a_drv, bus.b_ld_imm, bus.b_ld_bus, bus.b_drv,
                  bus.a_lrst, bus.b_lrst, bus.alu_ld, bus.alu_drv, bus.out_ld};
  function automatic ev_t mk(logic [3:0] p, logic [7:0] r, logic [10:0] s, logic h);
    logic [3:0] o = r[7:4];
    mk = '{pc: p, imm: r[3:0], s: s, op: (o >= 4'd5 && o <= 4'd8) ? r[5:4] : 2'd0, h: h};
  endfunction
  // Executes the program one instruction at a time, emitting what each cycle must show
  task automatic build(input int n, input bit rnd, input logic [1:0] fix);
    logic [3:0]  p = 4'd0;
    logic [3:0]  o;
    logic [7:0]  r = 8'd0;
    logic        z = 1'b0, c = 1'b0;
    logic [1:0]  nzc;
    logic [10:0] s;
    exp_q.delete();
    zc.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mk(p, r, 11'd0, 1'b0));
      r = mem[p];
      p = p + 4'd1;
      exp_q.push_back(mk(p, r, 11'd0, 1'b0));
      o = r[7:4];
      if (o == 4'hF) begin
        exp_q.push_back(mk(p, r, 11'd0, 1'b1));
        return;
      end
      case (o)
        4'h1: s = S_AI;
        4'h2: s = S_BI;
        4'h3: s = S_AD | S_BB;
        4'h4: s = S_BD | S_AB;
        4'h5, 4'h6, 4'h7, 4'h8: s = S_BD | S_ALD;
        4'h9: s = S_AD | S_OUT;
        4'hD: s = S_AR;
        4'hE: s = S_BR;
        default: s = 11'd0;
      endcase
      exp_q.push_back(mk(p, r, s, 1'b0));
      if (o == 4'hA || (o == 4'hB && z) || (o == 4'hC && c)) p = r[3:0];
      if (o >= 4'd5 && o <= 4'd8) begin
        nzc = rnd ? 2'($urandom) : fix;
        zc.push_back(nzc);
        exp_q.push_back(mk(p, r, S_ADRV | S_AB, 1'b0));
        {z, c} = nzc;
      end
    end
  endtask
  task automatic drive(input int stall);
    bus.en   = $urandom_range(99) >= stall;
    bus.z_in = zrd < zc.size() ? zc[zrd][1] : 1'($urandom);
    bus.c_in = zrd < zc.size() ? zc[zrd][0] : 1'($urandom);
  endtask
  // kill>0 asserts grst on that EXEC2 occurrence instead of running to the end
  task automatic run(input int stall, input int kill);
    int seen = 0;
    @(posedge clk);
    #2;
    drive(stall);
    grst   = 1'b0;
    active = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (abort || rd >= exp_q.size() || halt_cmp >= 3) break;
      if (bus.alu_drv) seen++;
      if (kill != 0 && seen == kill) break;
      drive(stall);
    end
    grst   = 1'b1;
    active = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
  endtask
  task automatic fill();
    foreach (mem[i]) mem[i] = 8'hF0;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.z_in = 1'b0;
    bus.c_in = 1'b0;
    fill();
    #1 grst = 1'b1;
    repeat (3) @(posedge clk);
    mem[0] = 8'h13; mem[1] = 8'h24; mem[2] = 8'h50; mem[3] = 8'h90;
    build(20, 1'b0, 2'b00); run(0, 0);
    build(20, 1'b0, 2'b01); run(50, 0);
    fill();
    mem[0] = 8'h12; mem[1] = 8'h22; mem[2] = 8'h60; mem[3] = 8'hB9; mem[4] = 8'h90;
    build(20, 1'b0, 2'b10); run(0, 0);
    build(20, 1'b0, 2'b00); run(30, 0);
    mem[3] = 8'h50;
    build(20, 1'b0, 2'b11); run(0, 2);
    fill();
    mem[0] = 8'hB9; mem[1] = 8'hCA; mem[2] = 8'h90;
    build(20, 1'b0, 2'b00); run(0, 0);
    fill();
    mem[0] = 8'h90; mem[1] = 8'hAF; mem[15] = 8'hA0;
    build(9, 1'b0, 2'b00); run(20, 0);
    fill();
    mem[0] = 8'h15; mem[1] = 8'h30; mem[2] = 8'h40; mem[3] = 8'hD0; mem[4] = 8'hE0; mem[5] = 8'h90;
    build(20, 1'b0, 2'b00); run(60, 0);
    for (int t = 0; t < 12; t++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      build(25, 1'b1, 2'b00);
      run(25, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial forever begin
    ev_t e, a;
    @(negedge clk);
    checks++;
    if (!$onehot0({bus.a_drv, bus.b_drv, bus.alu_drv})) begin
      errors++;
      $display("FAIL bus_drivers got a/b/alu=%b want at most one set", {bus.a_drv, bus.b_drv, bus.alu_drv});
    end
    a = '{pc: bus.pc, imm: bus.imm, s: act_s, op: bus.alu_op, h: bus.halted};
    if (grst) begin
      rd = 0; zrd = 0; halt_cmp = 0; cyc = 0; abort = 1'b0;
      checks++;
      if (a != '0) begin
        errors++;
        $display("FAIL reset_state got pc=%h imm=%h s=%b op=%b h=%b want all zero", a.pc, a.imm, a.s, a.op, a.h);
      end
    end else if (active && !abort) begin
      cyc++;
      checks++;
      if (cyc > 3000) begin
        errors++;
        abort = 1'b1;
        $display("FAIL timeout got rd=%0d want %0d events consumed", rd, exp_q.size());
      end else if (rd >= exp_q.size()) begin
        errors++;
        $display("FAIL extra_cycle got pc=%h s=%b want no further activity", a.pc, a.s);
      end else begin
        e = exp_q[rd];
        if (!bus.en) e.s = 11'd0;
        if (a != e) begin
          errors++;
          $display("FAIL step%0d en=%b got pc=%h imm=%h s=%b op=%b h=%b want pc=%h imm=%h s=%b op=%b h=%b",
                   rd, bus.en, a.pc, a.imm, a.s, a.op, a.h, e.pc, e.imm, e.s, e.op, e.h);
        end
        if (e.h) halt_cmp++;
        else if (bus.en) begin
          if (e.s[1]) zrd++;
          rd++;
        end
      end
    end
  end
endmodule
